lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller between the core's memory stage and the word-addressed data memory. It accepts byte, halfword and word load/store requests over a valid/ready handshake and performs word-aligned accesses on the memory port: combinational read data, write on the clock edge when the write strobe is high. Sub-word stores use a two-cycle read-modify-write, because the memory only writes whole words. Misaligned or illegal requests return an error response and never touch memory.

## Interface
- No parameters. Data and address are 32 bits; the memory is word-addressed by address bits [31:2].
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3
- mem_we  out  1  memory write strobe
- mem_addr  out  32  memory address; bits [1:0] always 00
- mem_wdata  out  32  memory write word
- mem_rdata  in  32  memory read word (combinational from mem_addr)

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr and wdata.
  - If the request is misaligned or has an illegal funct3, go to RESP with err=1.
  - Otherwise go to ACCESS.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- Illegal funct3: 011, 110 or 111 for loads; anything other than 000/001/010 for stores.
- ACCESS: mem_addr={addr[31:2],2'b00}.
  - Load: select the byte at addr[1:0] or the halfword at addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW. Register the result into rsp_rdata and go to RESP.
  - SW: mem_we=1, mem_wdata=wdata, go to RESP.
  - SB/SH: merge wdata[7:0] or wdata[15:0] into mem_rdata at the selected lane, register the merged word, go to WRITE.
- WRITE: mem_we=1, mem_addr is unchanged, mem_wdata is the merged word. Go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable. On rsp_ready go to IDLE.
- mem_we is decoded from the state only: high in ACCESS for SW and in WRITE; never high in IDLE or RESP.
- mem_addr and mem_wdata are 0 in IDLE and RESP.
- Byte lanes are little-endian: addr[1:0]=00 selects bits [7:0], 11 selects bits [31:24].

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. Latched request registers clear to 0.
- Request accepted at edge N (req_valid & req_ready in cycle N-1):
  - Load or SW: ACCESS in cycle N, rsp_valid from cycle N+1.
  - SB/SH: ACCESS in N, WRITE in N+1, rsp_valid from N+2.
  - Error: rsp_valid from N, no memory cycle.
- The SW memory write lands at the edge that ends ACCESS. The SB/SH write lands at the edge that ends WRITE.
- No new request is accepted until the response handshake completes. Maximum one outstanding access.
- rsp_valid with rsp_ready already high: RESP lasts 1 cycle, and req_ready is high the next cycle.
- Back-to-back load throughput is one request per 3 cycles.
- Request inputs may change after acceptance without effect; only the latched copies are used.
- Reset asserted mid-operation: immediate return to IDLE, and mem_we drops asynchronously, so an RMW aborted in WRITE performs no write. The pending response is discarded.
- rsp_ready is ignored outside RESP.

## Test plan
- Memory word 0x40 = 0x8877_6655:
  - LB 0x43 -> rsp_rdata 0xFFFF_FF88.
  - LBU 0x43 -> 0x0000_0088.
  - LH 0x42 -> 0xFFFF_8877.
  - LHU 0x40 -> 0x0000_6655.
  - Each load: rsp_valid exactly 2 cycles after acceptance, mem_we never high.
- SW 0x10 data 0xDEAD_BEEF -> mem_we high for exactly 1 cycle with mem_addr 0x10; a following LW 0x10 returns 0xDEAD_BEEF.
- Word 0x20 = 0x1122_3344:
  - SB 0x21 data 0xAB -> mem_we pulse in the WRITE cycle only; word becomes 0x1122_AB44.
  - SH 0x22 data 0xCDEF -> word becomes 0xCDEF_AB44.
  - Each store: response 3 cycles after acceptance.
- LW 0x06, LH 0x01 and load funct3=011 -> each gives rsp_err=1 and rsp_rdata=0 one cycle after acceptance; mem_we stays 0 and memory is unchanged.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready -> IDLE next cycle; a second request is accepted then.
- Assert reset during the WRITE cycle of SB 0x30 -> mem_we falls immediately, the word at 0x30 is unchanged, and all outputs take their reset values.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word accesses onto a word-addressed memory,
// with read-modify-write for sub-word stores and error responses for bad requests.
//
// state  | meaning
// IDLE   | ready for a request; latches it on req_valid
// ACCESS | word read (loads, SB/SH) or word write (SW)
// WRITE  | writes the merged word of an SB/SH
// RESP   | response held until rsp_ready
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
  logic        err_q;

  logic        misalign, illegal, req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merge_val;

  always_comb begin
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we)
      illegal = !((req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010));
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    req_bad = misalign || illegal;
  end

  // Little-endian lane selection and merge into the word just read.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase
    merge_val = mem_rdata;
    if (f3_q[0])
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Memory strobes come straight from the state so a reset drops them at once.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q && (f3_q == 3'b010)) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          state_nx  = RESP;
        end else if (we_q) begin
          state_nx = WRITE;
        end else begin
          state_nx = RESP;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = merged_q;
        state_nx  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= req_bad;
      end
      if (state == ACCESS) begin
        if (!we_q) rdata_q <= load_val;
        merged_q <= merge_val;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of loads/stores/errors against a
// small word memory, plus backpressure and reset-during-write sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  int nchk = 0;
  int nerr = 0;

  lsu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;    // negedges from acceptance edge to first rsp_valid sample, +1
    int          we_at;  // sample index of the single write pulse, 0 = no write
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, wes, we_at, guard;
    logic [31:0] we_addr;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'b111;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; wes = 0; we_at = 0; we_addr = 32'h0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        wes++;
        if (we_at == 0) we_at = lat;
        we_addr = mem_addr;
      end
    end while (!rsp_valid && lat < 20);
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_err", idx), {31'h0, rsp_err}, {31'h0, v.err});
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d_wecount", idx), wes, (v.we_at != 0) ? 1 : 0);
    chk($sformatf("v%0d_weat", idx), we_at, v.we_at);
    if (v.we_at != 0) chk($sformatf("v%0d_weaddr", idx), we_addr, {v.addr[31:2], 2'b00});
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", idx), {31'h0, req_ready}, 32'h1);
    chk($sformatf("v%0d_idle_valid", idx), {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"},   {31'h0, rsp_err}, 32'h0);
    chk({tag, "_mem_we"},    {31'h0, mem_we}, 32'h0);
    chk({tag, "_mem_addr"},  mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 3'b000, 32'h43, 32'h0,        32'hFFFF_FF88, 1'b0, 2, 0};
    vecs[1]  = '{1'b0, 3'b100, 32'h43, 32'h0,        32'h0000_0088, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, 3'b001, 32'h42, 32'h0,        32'hFFFF_8877, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, 3'b101, 32'h40, 32'h0,        32'h0000_6655, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h8877_6655, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 3'b000, 32'h41, 32'h0,        32'h0000_0066, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 3'b001, 32'h40, 32'h0,        32'h0000_6655, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0};
    vecs[9]  = '{1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB, 32'h0,        1'b0, 3, 2};
    vecs[10] = '{1'b1, 3'b001, 32'h22, 32'h1234_CDEF, 32'h0,        1'b0, 3, 2};
    vecs[11] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hCDEF_AB44, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 3'b000, 32'h23, 32'h0000_005A, 32'h0,        1'b0, 3, 2};
    vecs[13] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h5AEF_AB44, 1'b0, 2, 0};
    vecs[14] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,         1'b1, 1, 0};
    vecs[15] = '{1'b0, 3'b001, 32'h01, 32'h0,        32'h0,         1'b1, 1, 0};
    vecs[16] = '{1'b0, 3'b011, 32'h40, 32'h0,        32'h0,         1'b1, 1, 0};
    vecs[17] = '{1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0};
    vecs[18] = '{1'b1, 3'b001, 32'h23, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0};
    vecs[19] = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h8877_6655, 1'b0, 2, 0};
    vecs[20] = '{1'b0, 3'b101, 32'h42, 32'h0,        32'h0000_8877, 1'b0, 2, 0};
    vecs[21] = '{1'b0, 3'b000, 32'h42, 32'h0,        32'h0000_0077, 1'b0, 2, 0};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2] = 32'h8877_6655;
    mem[32'h20 >> 2] = 32'h1122_3344;
    mem[32'h30 >> 2] = 32'h5566_7788;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst_held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_rel");

    for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

    // Backpressure: response held 5 cycles while another request waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h40; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_funct3 = 3'b000; req_addr = 32'h43;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'h0000_6655);
      chk($sformatf("bp_ready_%0d", i), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_idle_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp2_access_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    chk("bp2_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bp2_rdata", rsp_rdata, 32'hFFFF_FF88);
    @(negedge clk);
    chk("bp2_done", {31'h0, req_ready}, 32'h1);

    // Reset arrives during the WRITE cycle of SB 0x30.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'h99;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_access_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rmw_write_we", {31'h0, mem_we}, 32'h1);
    chk("rmw_write_addr", mem_addr, 32'h30);
    chk("rmw_write_data", mem_wdata, 32'h5566_7799);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    chk("rmw_mem_unchanged", mem[32'h30 >> 2], 32'h5566_7788);
    @(negedge clk);
    chk_reset_outs("rst_after");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
